mul_div_unit: RTL and testbench

- Iterative 16-bit multiply/divide execution unit that sits directly upstream of the register file's write port.
- It takes two operands read from the register file (read1/read2) and a destination register index.
- It computes the result over multiple cycles and issues a single-cycle write-back (wb_en, wb_reg, wb_data) that drives the register file's write_en, wreg and writedata.

---
 rtl/mdu_pkg.sv | 29 ++
 rtl/mul_div_unit_div_step.sv | 26 ++
 rtl/mul_div_unit.sv | 152 +++++++++++++++
 tb/tb_mul_div_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
package mdu_pkg;

  localparam int MDU_WIDTH  = 16;
  localparam int MDU_REG_AW = 3;
  localparam int CNT_W      = 5;

  // Counter value at which the 16th (final) iteration is performed.
  localparam logic [CNT_W-1:0] ITER_LAST = 5'd15;

  typedef enum logic [1:0] {
    MDU_MUL   = 2'b00,
    MDU_MULHU = 2'b01,
    MDU_DIVU  = 2'b10,
    MDU_REMU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } mdu_state_e;

  // Bit 1 of the opcode splits the multiply and divide families.
  function automatic logic op_is_div(input mdu_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/mul_div_unit_div_step.sv
// One restoring-division step: shift in the next dividend bit, try to
// subtract the divisor, keep the difference when it does not borrow.
module div_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             dbit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  // The partial remainder is always below the divisor, so the shifted
  // value fits in WIDTH+1 bits and the extra top bit of trial is a clean
  // borrow flag.
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  assign shifted = {rem_in, dbit};
  assign trial   = shifted - {2'b00, divisor};
  assign q_bit   = ~trial[WIDTH+1];
  assign rem_out = q_bit ? trial[WIDTH:0] : shifted[WIDTH:0];

endmodule

// File: rtl/mul_div_unit.sv
// Iterative 16-bit multiply/divide unit feeding the register file write
// port. One iteration per clock, single-cycle write-back strobe.
// Optional: define MDU_EARLY_OUT_EN to finish trivial operations
// (zero multiply operand, zero divisor) at the accepting edge.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH  = MDU_WIDTH,
  parameter int REG_AW = MDU_REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [WIDTH-1:0]  opa,
  input  logic [WIDTH-1:0]  opb,
  input  logic [REG_AW-1:0] dst,
  output logic              busy,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_reg,
  output logic [WIDTH-1:0]  wb_data
);

  mdu_state_e        state_q, state_d;
  mdu_op_e           op_in, op_q;
  logic [REG_AW-1:0] dst_q;
  logic [WIDTH-1:0]  opnd_q;     // multiplicand (MUL*) or divisor (DIV*)
  logic [2*WIDTH-1:0] prod_q;    // product; low half doubles as dividend/quotient
  logic [WIDTH:0]    rem_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              ld, step, fin;
  logic [WIDTH:0]    mul_sum;
  logic [2*WIDTH-1:0] mul_nxt;
  logic [WIDTH:0]    rem_nxt;
  logic              q_bit;
  logic [WIDTH-1:0]  quo_nxt;
  logic [2*WIDTH-1:0] prod_nxt;
  logic [WIDTH-1:0]  res_nxt;
  logic              eo;
  logic [WIDTH-1:0]  eo_res;

  assign op_in = mdu_op_e'(op);
  assign ld    = (state_q == IDLE) && start;
  assign step  = (state_q == RUN);
  assign fin   = step && (cnt_q == ITER_LAST);

`ifdef MDU_EARLY_OUT_EN
  // Zero-detect at acceptance: results known without iterating.
  always_comb begin
    eo     = 1'b0;
    eo_res = '0;
    if (!op_is_div(op_in)) begin
      eo = (opa == '0) || (opb == '0);
    end else begin
      eo     = (opb == '0);
      eo_res = (op_in == MDU_REMU) ? opa : '1;
    end
  end
`else
  assign eo     = 1'b0;
  assign eo_res = '0;
`endif

  // Shift-add multiply: conditionally add the multiplicand into the high
  // half, then shift the whole product right, retiring one multiplier bit.
  assign mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                   (prod_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_nxt = {mul_sum, prod_q[WIDTH-1:1]};

  // Dividend bits leave from the top of the low half while quotient bits
  // enter at the bottom. A zero divisor naturally yields all-ones/opa.
  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in  (rem_q),
    .dbit    (prod_q[WIDTH-1]),
    .divisor (opnd_q),
    .rem_out (rem_nxt),
    .q_bit   (q_bit)
  );
  assign quo_nxt = {prod_q[WIDTH-2:0], q_bit};

  assign prod_nxt = op_is_div(op_q) ? {prod_q[2*WIDTH-1:WIDTH], quo_nxt} : mul_nxt;

  // Final-iteration result selection.
  always_comb begin
    res_nxt = '0;
    case (op_q)
      MDU_MUL:   res_nxt = mul_nxt[WIDTH-1:0];
      MDU_MULHU: res_nxt = mul_nxt[2*WIDTH-1:WIDTH];
      MDU_DIVU:  res_nxt = quo_nxt;
      MDU_REMU:  res_nxt = rem_nxt[WIDTH-1:0];
      default:   res_nxt = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: accept in IDLE, iterate in RUN, one DONE cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = eo ? DONE : RUN;
      RUN:     if (cnt_q == ITER_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath, counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy    <= 1'b0;
      wb_en   <= 1'b0;
      wb_reg  <= '0;
      wb_data <= '0;
      op_q    <= MDU_MUL;
      dst_q   <= '0;
      opnd_q  <= '0;
      prod_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      busy  <= (state_d != IDLE);
      wb_en <= fin || (ld && eo);
      if (ld) begin
        op_q   <= op_in;
        dst_q  <= dst;
        cnt_q  <= '0;
        rem_q  <= '0;
        opnd_q <= op_is_div(op_in) ? opb : opa;
        prod_q <= {{WIDTH{1'b0}}, (op_is_div(op_in) ? opa : opb)};
        if (eo) begin
          wb_reg  <= dst;
          wb_data <= eo_res;
        end
      end else if (step) begin
        cnt_q  <= cnt_q + 5'd1;
        prod_q <= prod_nxt;
        rem_q  <= rem_nxt;
        if (fin) begin
          wb_reg  <= dst_q;
          wb_data <= res_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: table-driven vectors plus
// hand-written multi-cycle sequences, results checked via a scoreboard.
module tb_mul_div_unit;

  localparam int W  = 16;
  localparam int RA = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [W-1:0]  opa = '0;
  logic [W-1:0]  opb = '0;
  logic [RA-1:0] dst = '0;
  logic          busy;
  logic          wb_en;
  logic [RA-1:0] wb_reg;
  logic [W-1:0]  wb_data;

  mul_div_unit #(.WIDTH(W), .REG_AW(RA)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
    .dst(dst), .busy(busy), .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [W-1:0]  data;
    logic [RA-1:0] rg;
    int            cyc;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [1:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [RA-1:0] d;
    logic [W-1:0]  exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  function automatic bit early(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MDU_EARLY_OUT_EN
    if (!o[1]) return (a == 0) || (b == 0);
    return (b == 0);
`else
    return 1'b0;
`endif
  endfunction

  // Monitor: every write-back must match the oldest expectation, including
  // the cycle it appears on, and busy must still be high during it.
  always @(negedge clk) begin
    if (wb_en) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_wb: got reg %0d data %0h expected no write-back", wb_reg, wb_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wb_data", 32'(wb_data), 32'(e.data));
        chk("wb_reg", 32'(wb_reg), 32'(e.rg));
        chk("wb_cycle", 32'(cyc), 32'(e.cyc));
        chk("busy_at_wb", 32'(busy), 32'd1);
      end
    end
  end

  // Drive one request while idle; returns just after the accepting edge.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [RA-1:0] d, input logic [W-1:0] want);
    exp_t e;
    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b; dst = d;
    @(posedge clk); #1;
    e.data = want;
    e.rg   = d;
    e.cyc  = cyc + (early(o, a, b) ? 0 : 16);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    opa = $urandom; opb = $urandom;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) begin
        n_checks++;
        return;
      end
    end
    n_checks++;
    n_errors++;
    $display("FAIL wait_idle: got busy %0b pending %0d expected idle", busy, sb.size());
  endtask

  vec_t vecs[$];

  initial begin
    int acc;
    exp_t e;
    vecs.push_back('{2'b00, 16'd5,    16'd2,    3'd2, 16'd10});
    vecs.push_back('{2'b00, 16'hFFFF, 16'hFFFF, 3'd1, 16'h0001});
    vecs.push_back('{2'b01, 16'hFFFF, 16'hFFFF, 3'd7, 16'hFFFE});
    vecs.push_back('{2'b10, 16'd100,  16'd7,    3'd3, 16'd14});
    vecs.push_back('{2'b11, 16'd100,  16'd7,    3'd4, 16'd2});
    vecs.push_back('{2'b10, 16'hFFFF, 16'd1,    3'd5, 16'hFFFF});
    vecs.push_back('{2'b10, 16'd1234, 16'd0,    3'd6, 16'hFFFF});
    vecs.push_back('{2'b11, 16'd1234, 16'd0,    3'd0, 16'd1234});
    vecs.push_back('{2'b00, 16'h1234, 16'h5678, 3'd1, 16'h0060});
    vecs.push_back('{2'b01, 16'h1234, 16'h5678, 3'd2, 16'h0626});
    vecs.push_back('{2'b00, 16'd0,    16'd1234, 3'd0, 16'd0});
    vecs.push_back('{2'b10, 16'hFFFF, 16'h0100, 3'd3, 16'h00FF});
    vecs.push_back('{2'b11, 16'hFFFF, 16'h0100, 3'd4, 16'h00FF});
    vecs.push_back('{2'b11, 16'd7,    16'd100,  3'd5, 16'd7});
    vecs.push_back('{2'b10, 16'd7,    16'd100,  3'd6, 16'd0});

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wb_en", 32'(wb_en), 32'd0);
    chk("rst_wb_reg", 32'(wb_reg), 32'd0);
    chk("rst_wb_data", 32'(wb_data), 32'd0);

    // Exact latency of one full-length operation
    issue(2'b00, 16'd5, 16'd2, 3'd2, 16'd10);
    repeat (16) @(negedge clk);
    chk("lat_wb_en", 32'(wb_en), 32'd1);
    chk("lat_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("lat_busy_fall", 32'(busy), 32'd0);
    chk("lat_wb_en_fall", 32'(wb_en), 32'd0);
    chk("hold_wb_data", 32'(wb_data), 32'd10);
    wait_idle();

    // Vector table
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].exp);
      wait_idle();
    end

    // start held high with operands changing: one result, next accept after idle
    @(negedge clk);
    start = 1'b1; op = 2'b00; opa = 16'd7; opb = 16'd9; dst = 3'd3;
    @(posedge clk); #1;
    acc = cyc;
    e.data = 16'd63; e.rg = 3'd3; e.cyc = acc + 16;
    sb.push_back(e);
    begin
      bit seen_idle;
      seen_idle = 1'b0;
      for (int i = 0; i < 40 && !seen_idle; i++) begin
        @(negedge clk);
        if (!busy) seen_idle = 1'b1;
        else begin opa = $urandom; opb = $urandom; dst = 3'($urandom); end
      end
      chk("held_idle_cycle", 32'(cyc), 32'(acc + 17));
    end
    op = 2'b10; opa = 16'd20; opb = 16'd3; dst = 3'd4;
    e.data = 16'd6; e.rg = 3'd4; e.cyc = acc + 18 + 16;
    sb.push_back(e);
    @(posedge clk); #1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Asynchronous reset in the middle of an operation
    issue(2'b00, 16'h1234, 16'h5678, 3'd6, 16'h0060);
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    void'(sb.pop_back());
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_wb_data", 32'(wb_data), 32'd0);
    @(negedge clk);
    chk("arst_wb_en", 32'(wb_en), 32'd0);
    chk("arst_wb_reg", 32'(wb_reg), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("arst_quiet", 32'(busy), 32'd0);
    issue(2'b00, 16'd3, 16'd4, 3'd5, 16'd12);
    wait_idle();

    if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL leftover: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
